// File: rtl/key_debounce.sv
// Per-key push-button conditioner: two-flop synchronizer, stability counter,
// and registered press/release strobes. Keys are processed independently.
module key_debounce #(
    parameter int N   = 4,
    parameter int DLY = 240000,   // stability time in cycles, at least 2
    parameter int CW  = 18        // 2**CW must cover DLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_n,
    output logic [N-1:0] key,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release
);

    localparam logic [CW-1:0] CntLast = CW'(DLY - 1);

    logic [N-1:0]  sync1_q;
    logic [N-1:0]  sync2_q;
    logic [N-1:0]  key_q;
    logic [N-1:0]  key_d;
    logic [N-1:0]  press_q;
    logic [N-1:0]  press_d;
    logic [N-1:0]  release_q;
    logic [N-1:0]  release_d;
    logic [N-1:0]  target;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    assign target = ~sync2_q;

    // A key only moves once its synchronized level has disagreed with the
    // accepted level for DLY consecutive cycles; any agreement restarts it.
    always_comb begin
        key_d     = key_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (target[i] != key_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    key_d[i]     = target[i];
                    press_d[i]   = target[i];
                    release_d[i] = ~target[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            key_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key         = key_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Cycle-by-cycle vector bench for key_debounce with N=4, DLY=4, CW=3.
// Each row is one clock edge; expected outputs are hand-derived per row.
module tb_key_debounce;

    localparam int N   = 4;
    localparam int DLY = 4;
    localparam int CW  = 3;

    typedef struct {
        logic         rst;
        logic [N-1:0] keyN;
        logic [N-1:0] expKey;
        logic [N-1:0] expPress;
        logic [N-1:0] expRelease;
        string        tag;
    } vec_t;

    typedef struct {
        logic [N-1:0] key;
        logic [N-1:0] press;
        logic [N-1:0] release_;
        string        tag;
        int           row;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] keyN;
    logic [N-1:0] key;
    logic [N-1:0] keyPress;
    logic [N-1:0] keyRelease;

    vec_t vecs[$];
    exp_t expQ[$];
    int   vectorCount;
    int   missCount;

    key_debounce #(
        .N  (N),
        .DLY(DLY),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (keyN),
        .key        (key),
        .key_press  (keyPress),
        .key_release(keyRelease)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Appends n identical rows to the vector table.
    task automatic addRows(input int n, input logic r, input logic [N-1:0] kn,
                           input logic [N-1:0] ek, input logic [N-1:0] ep,
                           input logic [N-1:0] er, input string tag);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst        = r;
            v.keyN       = kn;
            v.expKey     = ek;
            v.expPress   = ep;
            v.expRelease = er;
            v.tag        = tag;
            vecs.push_back(v);
        end
    endtask

    // Drives one row ahead of the next rising edge and queues its expectation.
    task automatic applyStimulus(input vec_t v, input int row);
        exp_t e;
        rst        = v.rst;
        keyN       = v.keyN;
        e.key      = v.expKey;
        e.press    = v.expPress;
        e.release_ = v.expRelease;
        e.tag      = v.tag;
        e.row      = row;
        expQ.push_back(e);
    endtask

    // Pops the oldest expectation and compares it against the settled outputs.
    task automatic checkOutput();
        exp_t e;
        vectorCount++;
        if (expQ.size() == 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard-underflow: no expectation queued, got key=%b press=%b release=%b",
                     key, keyPress, keyRelease);
        end else begin
            e = expQ.pop_front();
            if (key !== e.key || keyPress !== e.press || keyRelease !== e.release_) begin
                missCount++;
                $display("[TB] FAIL %s row %0d: got key=%b press=%b release=%b, expected key=%b press=%b release=%b",
                         e.tag, e.row, key, keyPress, keyRelease, e.key, e.press, e.release_);
            end
        end
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst         = 1'b1;
        keyN        = 4'b0000;

        // Reset with all keys held down, then press accepted on the 6th edge.
        addRows(3, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, "reset-hold");
        addRows(5, 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, "reset-exit-wait");
        addRows(1, 1'b0, 4'b0000, 4'hF, 4'hF, 4'h0, "reset-exit-press");
        addRows(1, 1'b0, 4'b0000, 4'hF, 4'h0, 4'h0, "reset-exit-held");
        addRows(5, 1'b0, 4'b1111, 4'hF, 4'h0, 4'h0, "all-release-wait");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'hF, "all-release");
        addRows(2, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "idle");

        // Clean press and release on key 0.
        addRows(5, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0, "k0-press-wait");
        addRows(1, 1'b0, 4'b1110, 4'h1, 4'h1, 4'h0, "k0-press");
        addRows(2, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, "k0-held");
        addRows(5, 1'b0, 4'b1111, 4'h1, 4'h0, 4'h0, "k0-release-wait");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h1, "k0-release");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "k0-idle");

        // Key 1 bounces with runs shorter than DLY, then settles low.
        addRows(3, 1'b0, 4'b1101, 4'h0, 4'h0, 4'h0, "k1-bounce-low");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "k1-bounce-high");
        addRows(3, 1'b0, 4'b1101, 4'h0, 4'h0, 4'h0, "k1-bounce-low");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "k1-bounce-high");
        addRows(4, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "k1-bounce-settle");
        addRows(5, 1'b0, 4'b1101, 4'h0, 4'h0, 4'h0, "k1-press-wait");
        addRows(1, 1'b0, 4'b1101, 4'h2, 4'h2, 4'h0, "k1-press");
        addRows(1, 1'b0, 4'b1101, 4'h2, 4'h0, 4'h0, "k1-held");
        addRows(5, 1'b0, 4'b1111, 4'h2, 4'h0, 4'h0, "k1-release-wait");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h2, "k1-release");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "k1-idle");

        // Keys 2 and 3 together, then staggered by two cycles.
        addRows(5, 1'b0, 4'b0011, 4'h0, 4'h0, 4'h0, "k23-press-wait");
        addRows(1, 1'b0, 4'b0011, 4'hC, 4'hC, 4'h0, "k23-press");
        addRows(1, 1'b0, 4'b0011, 4'hC, 4'h0, 4'h0, "k23-held");
        addRows(5, 1'b0, 4'b1111, 4'hC, 4'h0, 4'h0, "k23-release-wait");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'hC, "k23-release");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "k23-idle");
        addRows(2, 1'b0, 4'b1011, 4'h0, 4'h0, 4'h0, "stagger-k2-first");
        addRows(3, 1'b0, 4'b0011, 4'h0, 4'h0, 4'h0, "stagger-wait");
        addRows(1, 1'b0, 4'b0011, 4'h4, 4'h4, 4'h0, "stagger-k2-press");
        addRows(1, 1'b0, 4'b0011, 4'h4, 4'h0, 4'h0, "stagger-gap");
        addRows(1, 1'b0, 4'b0011, 4'hC, 4'h8, 4'h0, "stagger-k3-press");
        addRows(1, 1'b0, 4'b0011, 4'hC, 4'h0, 4'h0, "stagger-held");
        addRows(5, 1'b0, 4'b1111, 4'hC, 4'h0, 4'h0, "stagger-release-wait");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'hC, "stagger-release");
        addRows(1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "stagger-idle");

        // Reset lands when key 0's count is at 2; the strobe that would have
        // appeared during reset must be lost and the latency restarts.
        addRows(4, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0, "midcount-run");
        addRows(2, 1'b1, 4'b1110, 4'h0, 4'h0, 4'h0, "midcount-reset");
        addRows(5, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0, "midcount-restart-wait");
        addRows(1, 1'b0, 4'b1110, 4'h1, 4'h1, 4'h0, "midcount-press");
        addRows(1, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, "midcount-held");

        // Reset while a key is accepted clears it without a release strobe.
        addRows(1, 1'b1, 4'b1110, 4'h0, 4'h0, 4'h0, "pressed-reset");
        addRows(6, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, "pressed-reset-quiet");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
            @(posedge clk);
            #1;
            checkOutput();
        end

        vectorCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL scoreboard-drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
